// File: rtl/midi_msg_receiver.sv
// midi_msg_receiver
// -----------------------------------------------------------------------------
// Serial MIDI input block: synchroniser -> 8N1 UART receiver -> channel-voice
// message assembler with running status.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per MIDI bit (>= 4)
//   SYNC_STAGES   synchroniser depth on midi_in (>= 2)
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   midi_in     asynchronous serial line, idle high, LSB first
//   byte_data   last correctly framed byte
//   byte_valid  one-cycle pulse when byte_data updates
//   frame_err   one-cycle pulse when a stop bit is sampled low
//   msg_status  status byte of the presented message
//   msg_data1   first data byte
//   msg_data2   second data byte (0 for one-data-byte messages)
//   msg_valid   message presented, held until accepted
//   msg_ready   consumer accept
//   overrun     one-cycle pulse when a completed message is dropped
// -----------------------------------------------------------------------------
module midi_msg_receiver #(
    parameter int CLKS_PER_BIT = 128,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_e;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], midi_in};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    rx_state_e     state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + 1'b1;
        idx_d        = idx_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Mid-start-bit check: a line already back high is a glitch.
                if (timer_q == HALF_M1) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d        = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    if (rx_s) begin
                        byte_data_d  = shift_q;
                        byte_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Wait for the line to recover so a held-low line reports once.
                timer_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Message assembler
    // ------------------------------------------------------------------
    logic [7:0] rs_q, rs_d;
    logic       dcnt_q, dcnt_d;
    logic [6:0] part_q, part_d;
    logic [7:0] status_q, status_d;
    logic [6:0] d1_q, d1_d;
    logic [6:0] d2_q, d2_d;
    logic       mvalid_q, mvalid_d;
    logic       overrun_q, overrun_d;

    logic       cmp;
    logic [6:0] c1, c2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs_q      <= '0;
            dcnt_q    <= 1'b0;
            part_q    <= '0;
            status_q  <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            mvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rs_q      <= rs_d;
            dcnt_q    <= dcnt_d;
            part_q    <= part_d;
            status_q  <= status_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            mvalid_q  <= mvalid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        rs_d      = rs_q;
        dcnt_d    = dcnt_q;
        part_d    = part_q;
        status_d  = status_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        mvalid_d  = mvalid_q;
        overrun_d = 1'b0;
        cmp       = 1'b0;
        c1        = '0;
        c2        = '0;

        // Real-time bytes (0xF8-0xFF) fall through untouched.
        if (byte_valid_q && byte_data_q < 8'hF8) begin
            if (byte_data_q >= 8'hF0) begin
                rs_d   = '0;
                dcnt_d = 1'b0;
            end else if (byte_data_q[7]) begin
                rs_d   = byte_data_q;
                dcnt_d = 1'b0;
            end else if (rs_q != 8'h00) begin
                if (!dcnt_q) begin
                    // 0xC_/0xD_ carry a single data byte.
                    if (rs_q[7:5] == 3'b110) begin
                        cmp = 1'b1;
                        c1  = byte_data_q[6:0];
                    end else begin
                        part_d = byte_data_q[6:0];
                        dcnt_d = 1'b1;
                    end
                end else begin
                    cmp    = 1'b1;
                    c1     = part_q;
                    c2     = byte_data_q[6:0];
                    dcnt_d = 1'b0;
                end
            end
        end

        if (cmp) begin
            if (!mvalid_q || msg_ready) begin
                status_d = rs_q;
                d1_d     = c1;
                d2_d     = c2;
                mvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (mvalid_q && msg_ready) begin
            mvalid_d = 1'b0;
        end
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign msg_status = status_q;
    assign msg_data1  = d1_q;
    assign msg_data2  = d2_q;
    assign msg_valid  = mvalid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_midi_msg_receiver.sv
module tb_midi_msg_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       midi_in;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic       msg_valid;
    logic       msg_ready;
    logic       overrun;

    midi_msg_receiver #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .midi_in   (midi_in),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .msg_status(msg_status),
        .msg_data1 (msg_data1),
        .msg_data2 (msg_data2),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int ferr_cnt    = 0;
    int ovr_cnt     = 0;

    logic [7:0]  exp_bytes[$];
    logic [21:0] exp_msgs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid) begin
                if (exp_bytes.size() == 0) begin
                    chk("byte_unexpected", {24'h0, byte_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("byte_data", {24'h0, byte_data}, {24'h0, exp_bytes.pop_front()});
                end
            end
            if (msg_valid && msg_ready) begin
                if (exp_msgs.size() == 0) begin
                    chk("msg_unexpected", {10'h0, msg_status, msg_data1, msg_data2}, 32'hFFFF_FFFF);
                end else begin
                    chk("msg", {10'h0, msg_status, msg_data1, msg_data2}, {10'h0, exp_msgs.pop_front()});
                end
            end
            if (frame_err) ferr_cnt++;
            if (overrun)   ovr_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Drive one 8N1 frame. abort_bit >= 0 stops driving at the start of that data bit.
    task automatic drive_frame(input logic [7:0] b, input logic stopbit, input int abort_bit);
        midi_in = 1'b0;
        ticks(CPB);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) return;
            midi_in = b[i];
            ticks(CPB);
        end
        midi_in = stopbit;
        ticks(CPB);
        midi_in = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        exp_bytes.push_back(b);
        drive_frame(b, 1'b1, -1);
    endtask

    function automatic logic [21:0] m(input logic [7:0] s, input logic [6:0] a, input logic [6:0] d);
        return {s, a, d};
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_byte_data"},  {24'h0, byte_data}, 32'h0);
        chk({tag, "_byte_valid"}, {31'h0, byte_valid}, 32'h0);
        chk({tag, "_frame_err"},  {31'h0, frame_err}, 32'h0);
        chk({tag, "_msg"},        {10'h0, msg_status, msg_data1, msg_data2}, 32'h0);
        chk({tag, "_msg_valid"},  {31'h0, msg_valid}, 32'h0);
        chk({tag, "_overrun"},    {31'h0, overrun}, 32'h0);
    endtask

    initial begin
        int f0;
        rst_n     = 1'b0;
        midi_in   = 1'b1;
        msg_ready = 1'b1;
        ticks(5);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        ticks(10);

        // Basic note-on
        exp_msgs.push_back(m(8'h90, 7'h3C, 7'h64));
        send(8'h90); send(8'h3C); send(8'h64);
        ticks(20);
        chk("basic_drained", exp_msgs.size(), 0);

        // Running status, then a one-data-byte program change
        exp_msgs.push_back(m(8'h90, 7'h3C, 7'h64));
        exp_msgs.push_back(m(8'h90, 7'h3C, 7'h00));
        exp_msgs.push_back(m(8'hC5, 7'h07, 7'h00));
        send(8'h90); send(8'h3C); send(8'h64); send(8'h3C); send(8'h00);
        send(8'hC5); send(8'h07);
        ticks(20);
        chk("rs_drained", exp_msgs.size(), 0);

        // Real-time byte inside a message
        exp_msgs.push_back(m(8'h90, 7'h3C, 7'h64));
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        ticks(20);
        chk("rt_drained", exp_msgs.size(), 0);

        // Backpressure: second note is dropped, first held stable
        msg_ready = 1'b0;
        exp_msgs.push_back(m(8'h90, 7'h3C, 7'h64));
        send(8'h90); send(8'h3C); send(8'h64);
        ticks(10);
        chk("bp_valid_held", {31'h0, msg_valid}, 32'h1);
        chk("bp_fields_1", {10'h0, msg_status, msg_data1, msg_data2}, {10'h0, m(8'h90, 7'h3C, 7'h64)});
        send(8'h40); send(8'h50);
        ticks(10);
        chk("bp_overrun_cnt", ovr_cnt, 1);
        chk("bp_fields_2", {10'h0, msg_status, msg_data1, msg_data2}, {10'h0, m(8'h90, 7'h3C, 7'h64)});
        msg_ready = 1'b1;
        tick();
        chk("bp_valid_drop", {31'h0, msg_valid}, 32'h0);
        chk("bp_drained", exp_msgs.size(), 0);
        ticks(10);

        // Short low glitch on an idle line
        f0 = ferr_cnt;
        midi_in = 1'b0;
        ticks(4);
        midi_in = 1'b1;
        ticks(40);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_bytes", exp_bytes.size(), 0);

        // Framing error with line held low, then recovery
        f0 = ferr_cnt;
        drive_frame(8'h55, 1'b0, -1);
        midi_in = 1'b0;
        ticks(40);
        midi_in = 1'b1;
        ticks(20);
        chk("ferr_count", ferr_cnt - f0, 1);
        send(8'h80);
        ticks(10);
        chk("ferr_recover_byte", {24'h0, byte_data}, 32'h80);
        chk("ferr_bytes_drained", exp_bytes.size(), 0);

        // Reset during data bit 4 of 0x90
        drive_frame(8'h90, 1'b1, 4);
        midi_in = 1'b1;    // bit 4 of 0x90
        ticks(CPB / 2);
        rst_n = 1'b0;
        tick();
        chk_outputs_zero("midreset");
        ticks(4);
        rst_n = 1'b1;
        ticks(10);
        exp_msgs.push_back(m(8'h80, 7'h40, 7'h00));
        send(8'h80); send(8'h40); send(8'h00);
        ticks(20);
        chk("post_reset_msgs", exp_msgs.size(), 0);
        chk("post_reset_bytes", exp_bytes.size(), 0);
        chk("total_overruns", ovr_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
